// File: rtl/core_pkg.sv
// Types and constants shared by the pipeline control blocks.
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hz_perf_counter.sv
// 32-bit wrapping event counter with synchronous clear.
// Present only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hz_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for the PC, IF/ID and ID/EX registers.
// Optional performance counters are enabled by HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int DIV_LATENCY    = 8,
  parameter int REDIRECT_FLUSH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_is_load_i,
  input  logic        ex_div_start_i,
  input  logic        ex_redirect_i,
  input  logic        mem_busy_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        ex_mem_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int CW = $clog2(DIV_LATENCY);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 2);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          load_use;
  logic          redirect_acc;

  assign load_use = ex_is_load_i && (ex_rd_addr_i != REG_ZERO) &&
                    ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    redirect_acc   = 1'b0;
    if (rst) begin
      state_d   = RUN;
      div_cnt_d = '0;
    end else if (mem_busy_i) begin
      // Bus wait freezes everything, including any sequence in flight.
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
    end else begin
      case (state_q)
        DIV_WAIT: begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          if (div_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            div_cnt_d = div_cnt_q - 1'b1;
          end
        end
        REDIRECT: begin
          if_id_flush_o = 1'b1;
          state_d       = RUN;
        end
        default: begin
          if (ex_redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            redirect_acc  = 1'b1;
            if (REDIRECT_FLUSH == 2) state_d = REDIRECT;
          end else if (ex_div_start_i) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            div_cnt_d     = DIV_LOAD;
            state_d       = DIV_WAIT;
          end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end
        end
      endcase
    end
  end

  assign state_o = rst ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  hz_perf_counter u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pc_stall_o),
    .cnt_o (stall_cnt)
  );

  hz_perf_counter u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (redirect_acc),
    .cnt_o (flush_cnt)
  );

  assign stall_cnt_o = rst ? 32'd0 : stall_cnt;
  assign flush_cnt_o = rst ? 32'd0 : flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle model comparison plus directed scenarios.
module tb_pipe_hazard_ctrl;

  localparam int DL = 8;
  localparam int RF = 2;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_div_start, ex_redirect, mem_busy;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_LATENCY(DL), .REDIRECT_FLUSH(RF)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_uses_rs1_i  (id_uses_rs1),
    .id_uses_rs2_i  (id_uses_rs2),
    .ex_rd_addr_i   (ex_rd_addr),
    .ex_is_load_i   (ex_is_load),
    .ex_div_start_i (ex_div_start),
    .ex_redirect_i  (ex_redirect),
    .mem_busy_i     (mem_busy),
    .pc_stall_o     (pc_stall),
    .if_id_stall_o  (if_id_stall),
    .id_ex_stall_o  (id_ex_stall),
    .ex_mem_stall_o (ex_mem_stall),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .state_o        (state),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining hold cycles of a divide, a pending second redirect flush, event tallies.
  int          m_div_left = 0;
  bit          m_redir    = 1'b0;
  logic [31:0] m_scnt     = '0;
  logic [31:0] m_fcnt     = '0;

  always @(negedge clk) begin
    logic e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf, lu, acc;
    logic [1:0] e_st;
    e_pc = 0; e_ifs = 0; e_ids = 0; e_exs = 0; e_iff = 0; e_idf = 0; acc = 0; e_st = 2'd0;
    lu = ex_is_load && ex_rd_addr != 5'd0 &&
         ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    if (!rst) begin
      e_st = (m_div_left > 0) ? 2'd1 : (m_redir ? 2'd2 : 2'd0);
      if (mem_busy) begin
        e_pc = 1; e_ifs = 1; e_ids = 1; e_exs = 1;
      end else if (m_div_left > 0) begin
        e_pc = 1; e_ifs = 1; e_ids = 1;
      end else if (m_redir) begin
        e_iff = 1;
      end else if (ex_redirect) begin
        e_iff = 1; e_idf = 1; acc = 1;
      end else if (ex_div_start) begin
        e_pc = 1; e_ifs = 1; e_ids = 1;
      end else if (lu) begin
        e_pc = 1; e_ifs = 1; e_idf = 1;
      end
    end
    chk1("pc_stall", pc_stall, e_pc);
    chk1("if_id_stall", if_id_stall, e_ifs);
    chk1("id_ex_stall", id_ex_stall, e_ids);
    chk1("ex_mem_stall", ex_mem_stall, e_exs);
    chk1("if_id_flush", if_id_flush, e_iff);
    chk1("id_ex_flush", id_ex_flush, e_idf);
    chk32("state", 32'(state), 32'(e_st));
    chk32("stall_cnt", stall_cnt, (PERF && !rst) ? m_scnt : 32'd0);
    chk32("flush_cnt", flush_cnt, (PERF && !rst) ? m_fcnt : 32'd0);
    if (rst) begin
      m_div_left = 0; m_redir = 0; m_scnt = '0; m_fcnt = '0;
    end else begin
      if (e_pc) m_scnt = m_scnt + 32'd1;
      if (acc)  m_fcnt = m_fcnt + 32'd1;
      if (!mem_busy) begin
        if (m_div_left > 0)      m_div_left = m_div_left - 1;
        else if (m_redir)        m_redir = 0;
        else if (ex_redirect)    m_redir = (RF == 2);
        else if (ex_div_start)   m_div_left = DL - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0;
    ex_div_start = 0; ex_redirect = 0; mem_busy = 0;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1;
  endtask

  // Runs one divide, with mem_busy on loop cycles ba and bb; counts held cycles.
  task automatic run_div(input int ba, input int bb, output int n, output int m);
    bit done;
    n = 0; m = 0; done = 0;
    for (int i = 0; i < 20; i++) begin
      ex_div_start = (i == 0);
      mem_busy     = (i == ba) || (i == bb);
      #1;
      if (!pc_stall) begin
        done = 1;
        break;
      end
      n++;
      if (ex_mem_stall) m++;
      tick();
    end
    if (!done) begin
      fails++;
      $display("FAIL div_release: stall never dropped within 20 cycles");
    end
    idle();
  endtask

  initial begin
    int n, m;
    rst = 1;
    id_rs1_addr = '1; id_rs2_addr = '1; ex_rd_addr = '1;
    id_uses_rs1 = 1; id_uses_rs2 = 1; ex_is_load = 1;
    ex_div_start = 1; ex_redirect = 1; mem_busy = 1;
    repeat (3) tick();
    #1;
    chk1("rst_pc_stall", pc_stall, 1'b0);
    chk1("rst_if_id_flush", if_id_flush, 1'b0);
    chk32("rst_state", 32'(state), 32'd0);
    chk32("rst_stall_cnt", stall_cnt, 32'd0);
    tick();
    rst = 0;
    idle();
    #1;
    chk32("post_rst_state", 32'(state), 32'd0);
    tick();

    // Load-use on rs2: exactly one bubble.
    set_lu();
    #1;
    chk1("lu_pc_stall", pc_stall, 1'b1);
    chk1("lu_if_id_stall", if_id_stall, 1'b1);
    chk1("lu_id_ex_flush", id_ex_flush, 1'b1);
    chk1("lu_id_ex_stall", id_ex_stall, 1'b0);
    tick();
    idle();
    #1;
    chk1("lu_clear", pc_stall, 1'b0);
    tick();
    // x0 destination never interlocks.
    ex_is_load = 1; id_uses_rs2 = 1;
    #1;
    chk1("lu_x0", pc_stall, 1'b0);
    tick();
    // Matching rs1 that is not read.
    idle();
    ex_is_load = 1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 0;
    #1;
    chk1("lu_unused_rs1", pc_stall, 1'b0);
    tick();
    idle();
    tick();

    run_div(-1, -1, n, m);
    chk32("div_stall_cycles", n, DL);
    chk32("div_exmem_cycles", m, 0);
    tick();
    run_div(3, 4, n, m);
    chk32("div_busy_stall_cycles", n, DL + 2);
    chk32("div_busy_exmem_cycles", m, 2);
    tick();

    // Redirect beats a simultaneous load-use; second flush cycle ignores hazards.
    set_lu();
    ex_redirect = 1;
    #1;
    chk1("rd0_if_id_flush", if_id_flush, 1'b1);
    chk1("rd0_id_ex_flush", id_ex_flush, 1'b1);
    chk1("rd0_pc_stall", pc_stall, 1'b0);
    tick();
    ex_redirect = 0;
    #1;
    chk1("rd1_if_id_flush", if_id_flush, 1'b1);
    chk1("rd1_id_ex_flush", id_ex_flush, 1'b0);
    chk1("rd1_pc_stall", pc_stall, 1'b0);
    chk32("rd1_state", 32'(state), 32'd2);
    tick();
    idle();
    #1;
    chk32("rd2_state", 32'(state), 32'd0);
    tick();

    // Reset during the third DIV_WAIT cycle.
    ex_div_start = 1;
    tick();
    ex_div_start = 0;
    tick();
    tick();
    rst = 1;
    #1;
    chk1("rst_div_pc_stall", pc_stall, 1'b0);
    tick();
    rst = 0;
    #1;
    chk1("after_rst_div_pc_stall", pc_stall, 1'b0);
    chk32("after_rst_div_state", 32'(state), 32'd0);
    tick();
    run_div(-1, -1, n, m);
    chk32("div_after_rst_cycles", n, DL);
    tick();

    // Counter scenario from a clean reset.
    rst = 1;
    tick();
    rst = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_lu();
      tick();
      idle();
      tick();
    end
    run_div(-1, -1, n, m);
    #1;
    chk32("perf_stall_cnt", stall_cnt, PERF ? 32'd11 : 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      ex_redirect = 1;
      tick();
      idle();
      tick();
    end
    tick();
    #1;
    chk32("perf_flush_cnt", flush_cnt, PERF ? 32'd2 : 32'd0);
    chk32("perf_stall_cnt_hold", stall_cnt, PERF ? 32'd11 : 32'd0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
